adc_sample_sequencer: RTL and testbench

Sequences the external 8-bit ADC once per switching period for the digital buck loop. It launches a conversion at a programmable point of the DPWM period counter, waits for end-of-conversion, performs the read strobe and latches the result. It then hands the sample to the encoder/compensator path with a one-cycle valid pulse, and reports missed triggers and ADC timeouts.

---
 rtl/adc_sample_sequencer.sv | 153 +++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_sequencer.sv
// Per-period ADC sampling sequencer: launches a conversion at a fixed DPWM count,
// waits for end-of-conversion, strobes the read and hands the sample downstream.
module adc_sample_sequencer #(
    parameter int unsigned CNT_W     = 6,
    parameter int unsigned SAMPLE_PT = 32,
    parameter int unsigned CONV_LOW  = 2,
    parameter int unsigned RD_LOW    = 3,
    parameter int unsigned TIMEOUT   = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] count,
    input  logic             eoc_bar,
    input  logic [7:0]       adc_data,
    output logic             convst_bar,
    output logic             rd_bar,
    output logic [7:0]       sample,
    output logic             sample_valid,
    output logic             busy,
    output logic             missed_trig,
    output logic             timeout_err
);

    localparam int unsigned MAX_A   = (CONV_LOW > RD_LOW) ? CONV_LOW : RD_LOW;
    localparam int unsigned MAX_CNT = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
    localparam int unsigned CW      = $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StWaitEoc,
        StRead
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            armed_q, armed_d;
    logic            eoc_meta_q, eoc_s_q;
    logic            convst_q, convst_d;
    logic            rd_q, rd_d;
    logic [7:0]      sample_q, sample_d;
    logic            valid_q, valid_d;
    logic            busy_q;
    logic            missed_q, missed_d;
    logic            timeout_q, timeout_d;
    logic            at_pt;
    logic            trig;

    // armed re-arms only once count leaves SAMPLE_PT, so a stalled counter fires once
    assign at_pt   = (count == CNT_W'(SAMPLE_PT));
    assign trig    = at_pt & armed_q;
    assign armed_d = ~at_pt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        convst_d  = convst_q;
        rd_d      = rd_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        missed_d  = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (trig && en) begin
                    state_d  = StConv;
                    convst_d = 1'b0;
                    cnt_d    = CW'(1);
                end
            end
            StConv: begin
                missed_d = trig;
                if (cnt_q == CW'(CONV_LOW)) begin
                    state_d  = StWaitEoc;
                    convst_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWaitEoc: begin
                missed_d = trig;
                if (!eoc_s_q) begin
                    state_d = StRead;
                    rd_d    = 1'b0;
                    cnt_d   = CW'(1);
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StRead: begin
                missed_d = trig;
                if (cnt_q == CW'(RD_LOW)) begin
                    state_d  = StIdle;
                    rd_d     = 1'b1;
                    sample_d = adc_data;
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            armed_q    <= 1'b1;
            eoc_meta_q <= 1'b1;
            eoc_s_q    <= 1'b1;
            convst_q   <= 1'b1;
            rd_q       <= 1'b1;
            sample_q   <= 8'h00;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            missed_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            eoc_meta_q <= eoc_bar;
            eoc_s_q    <= eoc_meta_q;
            convst_q   <= convst_d;
            rd_q       <= rd_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            busy_q     <= (state_d != StIdle);
            missed_q   <= missed_d;
            timeout_q  <= timeout_d;
        end
    end

    assign convst_bar   = convst_q;
    assign rd_bar       = rd_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign missed_trig  = missed_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboard bench for adc_sample_sequencer: a behavioural ADC answers convst_bar,
// expected samples are queued at stimulus time and popped on sample_valid.
module tb_adc_sample_sequencer;

    localparam int unsigned CNT_W     = 6;
    localparam int unsigned SAMPLE_PT = 32;
    localparam int unsigned CONV_LOW  = 2;
    localparam int unsigned RD_LOW    = 3;
    localparam int unsigned TIMEOUT   = 31;

    logic             clk;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] count;
    logic             eoc_bar;
    logic [7:0]       adc_data;
    logic             convst_bar;
    logic             rd_bar;
    logic [7:0]       sample;
    logic             sample_valid;
    logic             busy;
    logic             missed_trig;
    logic             timeout_err;

    adc_sample_sequencer #(
        .CNT_W     (CNT_W),
        .SAMPLE_PT (SAMPLE_PT),
        .CONV_LOW  (CONV_LOW),
        .RD_LOW    (RD_LOW),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .count        (count),
        .eoc_bar      (eoc_bar),
        .adc_data     (adc_data),
        .convst_bar   (convst_bar),
        .rd_bar       (rd_bar),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .missed_trig  (missed_trig),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    int         eoc_delay;
    int         n_launch, n_valid, n_missed, n_timeout, n_rd_fall;
    int         conv_w, rd_w;
    logic       prev_convst, prev_rd;
    logic [CNT_W-1:0] drv_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ADC model: eoc_bar falls eoc_delay cycles after convst_bar rises (0 = never),
    // returns high once the read strobe is seen
    initial begin : adc_model
        int   ecnt;
        logic prev_cv;
        eoc_bar = 1'b1;
        ecnt    = 0;
        prev_cv = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!rd_bar) eoc_bar = 1'b1;
            if (convst_bar && !prev_cv && eoc_delay != 0) begin
                ecnt = eoc_delay;
            end else if (ecnt > 0) begin
                ecnt--;
                if (ecnt == 0) eoc_bar = 1'b0;
            end
            prev_cv = convst_bar;
        end
    end

    task automatic clear_counts();
        n_launch  = 0;
        n_valid   = 0;
        n_missed  = 0;
        n_timeout = 0;
        n_rd_fall = 0;
    endtask

    // One clock with output monitoring #1 after the edge
    task automatic tick();
        drv_count = count;
        @(posedge clk);
        #1;
        if (!convst_bar && prev_convst) begin
            n_launch++;
            conv_w = 0;
            check("launch_at_pt", 32'(drv_count), SAMPLE_PT);
        end
        if (!convst_bar) conv_w++;
        if (convst_bar && !prev_convst) check("convst_width", conv_w, CONV_LOW);
        if (!rd_bar && prev_rd) begin
            n_rd_fall++;
            rd_w = 0;
        end
        if (!rd_bar) rd_w++;
        if (rd_bar && !prev_rd) check("rd_width", rd_w, RD_LOW);
        if (sample_valid) begin
            n_valid++;
            if (exp_q.size() == 0) check("sb_extra_valid", 1, 0);
            else check("sample", sample, exp_q.pop_front());
        end
        if (missed_trig) begin
            n_missed++;
            check("missed_while_busy", busy, 1);
        end
        if (timeout_err) n_timeout++;
        prev_convst = convst_bar;
        prev_rd     = rd_bar;
    endtask

    task automatic run_counts(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) begin
            count = CNT_W'(c);
            tick();
        end
    endtask

    initial begin
        rst         = 1'b0;
        en          = 1'b0;
        count       = '0;
        adc_data    = 8'h00;
        eoc_delay   = 5;
        prev_convst = 1'b1;
        prev_rd     = 1'b1;
        conv_w      = 0;
        rd_w        = 0;
        clear_counts();

        repeat (3) @(posedge clk);
        #1;
        check("rst_convst_bar", convst_bar, 1);
        check("rst_rd_bar", rd_bar, 1);
        check("rst_sample", sample, 8'h00);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_missed_trig", missed_trig, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b1;

        // Nominal: three periods with distinct data, last one A5
        en = 1'b1;
        clear_counts();
        adc_data = 8'h3C; exp_q.push_back(8'h3C); run_counts(0, 63);
        check("nom_busy_idle", busy, 0);
        adc_data = 8'h5A; exp_q.push_back(8'h5A); run_counts(0, 63);
        check("nom_busy_idle", busy, 0);
        adc_data = 8'hA5; exp_q.push_back(8'hA5); run_counts(0, 63);
        check("nom_busy_idle", busy, 0);
        check("nom_launches", n_launch, 3);
        check("nom_valids", n_valid, 3);
        check("nom_missed", n_missed, 0);
        check("nom_timeouts", n_timeout, 0);
        check("nom_sb_drained", exp_q.size(), 0);

        // Timeout: ADC never answers; second timeout spills into the next period
        eoc_delay = 0;
        adc_data  = 8'hFF;
        clear_counts();
        run_counts(0, 63);
        run_counts(0, 63);
        run_counts(0, 7);
        check("to_timeouts", n_timeout, 2);
        check("to_launches", n_launch, 2);
        check("to_valids", n_valid, 0);
        check("to_rd_falls", n_rd_fall, 0);
        check("to_sample_kept", sample, 8'hA5);
        check("to_busy_idle", busy, 0);

        // Stalled counter at the sample point
        eoc_delay = 5;
        adc_data  = 8'h7E;
        clear_counts();
        exp_q.push_back(8'h7E);
        run_counts(0, 31);
        count = CNT_W'(SAMPLE_PT);
        for (int i = 0; i < 100; i++) tick();
        run_counts(33, 63);
        check("stall_launches", n_launch, 1);
        check("stall_valids", n_valid, 1);
        check("stall_missed", n_missed, 0);
        check("stall_sb_drained", exp_q.size(), 0);

        // Overrun: sample point every 8 cycles, slow ADC
        eoc_delay = 20;
        adc_data  = 8'hC3;
        clear_counts();
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'hC3);
        for (int i = 0; i <= 66; i++) begin
            count = CNT_W'(28 + (i % 8));
            tick();
        end
        check("ovr_launches", n_launch, 2);
        check("ovr_valids", n_valid, 2);
        check("ovr_missed", n_missed, 6);
        check("ovr_timeouts", n_timeout, 0);
        check("ovr_sb_drained", exp_q.size(), 0);

        // Enable dropped while waiting for EOC
        eoc_delay = 5;
        adc_data  = 8'h96;
        clear_counts();
        exp_q.push_back(8'h96);
        for (int c = 0; c <= 63; c++) begin
            count = CNT_W'(c);
            if (c == 36) en = 1'b0;
            tick();
        end
        run_counts(0, 63);
        check("en_off_launches", n_launch, 1);
        check("en_off_valids", n_valid, 1);
        en       = 1'b1;
        adc_data = 8'h69;
        exp_q.push_back(8'h69);
        run_counts(0, 63);
        check("en_on_launches", n_launch, 2);
        check("en_on_valids", n_valid, 2);
        check("en_sb_drained", exp_q.size(), 0);

        // Reset asserted while the read strobe is low
        adc_data = 8'h11;
        clear_counts();
        begin : find_read
            bit found;
            found = 1'b0;
            for (int c = 0; c <= 63; c++) begin
                count = CNT_W'(c);
                tick();
                if (!rd_bar) begin
                    found = 1'b1;
                    break;
                end
            end
            check("rd_low_seen", 32'(found), 1);
        end
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_rd_bar", rd_bar, 1);
        check("mid_rst_convst_bar", convst_bar, 1);
        check("mid_rst_sample", sample, 8'h00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", sample_valid, 0);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        prev_convst = 1'b1;
        prev_rd     = 1'b1;
        conv_w      = 0;
        rd_w        = 0;
        exp_q.delete();
        clear_counts();
        adc_data = 8'h5A;
        exp_q.push_back(8'h5A);
        run_counts(0, 63);
        check("post_rst_launches", n_launch, 1);
        check("post_rst_valids", n_valid, 1);
        check("post_rst_sample", sample, 8'h5A);
        check("post_rst_sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
